// File: rtl/toggle_cover_collector_if.sv
// Bus bundle for toggle_cover_collector: hit strobes, clear, event stream and coverage status.
// The master side stimulates and consumes events; the slave side is the collector.
interface toggle_cover_collector_if #(
    parameter int N_POINTS  = 42,
    parameter int IDX_WIDTH = 32
);
    localparam int CNT_W = $clog2(N_POINTS + 1);

    logic [N_POINTS-1:0]  valid;
    logic                 clear;
    logic                 ev_valid;
    logic                 ev_ready;
    logic [IDX_WIDTH-1:0] ev_index;
    logic [N_POINTS-1:0]  hit_map;
    logic [CNT_W-1:0]     hit_count;
    logic                 all_covered;

    modport master (
        output valid, clear, ev_ready,
        input  ev_valid, ev_index, hit_map, hit_count, all_covered
    );

    modport slave (
        input  valid, clear, ev_ready,
        output ev_valid, ev_index, hit_map, hit_count, all_covered
    );
endinterface

// File: rtl/toggle_cover_collector.sv
// Sticky toggle-coverage collector: records first hits per point and streams their
// global indices, lowest index first, through a small event FIFO.
module toggle_cover_collector #(
    parameter int N_POINTS    = 42,
    parameter int COVER_INDEX = 0,
    parameter int IDX_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      gbl_clk,
    input  logic                      reset,
    toggle_cover_collector_if.slave   bus
);
    localparam int CNT_W = $clog2(N_POINTS + 1);
    localparam int SEL_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [N_POINTS-1:0]  hit_map_q, hit_map_d;
    logic [N_POINTS-1:0]  pending_q, pending_d;
    logic [N_POINTS-1:0]  new_bits;
    logic [N_POINTS-1:0]  push_mask;
    logic [CNT_W-1:0]     hit_count_q, hit_count_d;
    logic [CNT_W-1:0]     new_count;
    logic [0:0]           state_q, state_d;
    logic [SEL_W-1:0]     sel;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [IDX_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [IDX_WIDTH-1:0] push_index;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 flush;

    // Reset and clear share one path; valid is discarded whenever either is active.
    assign flush    = !reset || bus.clear;
    assign new_bits = bus.valid & ~hit_map_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        new_count = '0;
        for (int i = 0; i < N_POINTS; i++) begin
            if (new_bits[i]) new_count = new_count + CNT_W'(1);
        end
    end

    // Scan downward so the last match is the lowest set pending bit.
    always_comb begin
        sel = '0;
        for (int i = N_POINTS - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = SEL_W'(i);
        end
    end

    assign push_index = IDX_WIDTH'(COVER_INDEX) + IDX_WIDTH'(sel);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = (state_q == S_DRAIN) && (!fifo_full || pop);
    assign push_mask  = push ? (N_POINTS'(1) << sel) : '0;

    always_comb begin
        hit_map_d   = hit_map_q | new_bits;
        hit_count_d = hit_count_q + new_count;
        pending_d   = (pending_q & ~push_mask) | new_bits;
        wr_ptr_d    = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        state_d     = state_q;
        case (state_q)
            S_IDLE:  if (pending_d != '0) state_d = S_DRAIN;
            S_DRAIN: if (pending_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge gbl_clk) begin
        if (flush) begin
            hit_map_q   <= '0;
            pending_q   <= '0;
            hit_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
        end else begin
            hit_map_q   <= hit_map_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge gbl_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_index;
    end

    assign bus.ev_valid    = !fifo_empty;
    assign bus.ev_index    = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.hit_map     = hit_map_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.all_covered = (hit_count_q == CNT_W'(N_POINTS));
endmodule

// File: tb/tb_toggle_cover_collector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a set-based
// coverage model (covered bitmap and outstanding-event set).
module tb_toggle_cover_collector;
    localparam int NP = 42;
    localparam int CI = 100;
    localparam int IW = 32;
    localparam int FD = 4;

    logic gbl_clk = 1'b0;
    logic reset   = 1'b0;

    always #5 gbl_clk = ~gbl_clk;

    toggle_cover_collector_if #(.N_POINTS(NP), .IDX_WIDTH(IW)) bus ();

    toggle_cover_collector #(
        .N_POINTS(NP), .COVER_INDEX(CI), .IDX_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .gbl_clk (gbl_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    bit [NP-1:0]   m_cov    = '0;
    bit [NP-1:0]   m_out    = '0;
    int            pop_log[$];
    bit            prev_stall = 1'b0;
    logic [IW-1:0] prev_idx   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: score the handshake seen before the edge, step the model, compare status.
    task automatic cycle();
        logic [NP-1:0] v;
        logic [NP-1:0] nb;
        logic          c;
        logic          r;
        int            k;
        if (prev_stall) begin
            check("hold_valid", bus.ev_valid, 1);
            check("hold_index", bus.ev_index, prev_idx);
        end
        if (bus.ev_valid && bus.ev_ready) begin
            k = int'(bus.ev_index) - CI;
            check("pop_in_range", (k >= 0 && k < NP), 1);
            if (k >= 0 && k < NP) begin
                check("pop_expected", m_out[k], 1);
                m_out[k] = 1'b0;
            end
            pop_log.push_back(int'(bus.ev_index));
        end
        prev_stall = bus.ev_valid && !bus.ev_ready && reset && !bus.clear;
        prev_idx   = bus.ev_index;
        v = bus.valid;
        c = bus.clear;
        r = reset;
        @(posedge gbl_clk);
        #1;
        if (!r || c) begin
            m_cov = '0;
            m_out = '0;
            check("flush_empty", bus.ev_valid, 0);
        end else begin
            nb    = v & ~m_cov;
            m_cov = m_cov | nb;
            m_out = m_out | nb;
        end
        check("hit_map", bus.hit_map, m_cov);
        check("hit_count", bus.hit_count, $countones(m_cov));
        check("all_covered", bus.all_covered, (m_cov == '1));
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        bus.valid    = '0;
        bus.ev_ready = 1'b1;
        budget       = 0;
        while ((m_out != '0 || bus.ev_valid) && budget < 200) begin
            cycle();
            budget++;
        end
        check(tag, (m_out == '0 && !bus.ev_valid), 1);
    endtask

    initial begin
        bus.valid    = '0;
        bus.clear    = 1'b0;
        bus.ev_ready = 1'b1;

        // Reset state, with valid asserted to show it is ignored.
        bus.valid = '1;
        cycle();
        cycle();
        check("rst_ev_valid", bus.ev_valid, 0);
        check("rst_hit_count", bus.hit_count, 0);
        check("rst_all_covered", bus.all_covered, 0);
        bus.valid = '0;
        reset     = 1'b1;
        cycle();

        // Single hit: valid[5] at t, event 105 at t+2.
        bus.valid = NP'(1) << 5;
        cycle();
        bus.valid = '0;
        check("single_t1_ev_valid", bus.ev_valid, 0);
        cycle();
        check("single_ev_valid", bus.ev_valid, 1);
        check("single_ev_index", bus.ev_index, CI + 5);
        check("single_hit_count", bus.hit_count, 1);
        cycle();
        check("single_done", bus.ev_valid, 0);

        // Batch of three points in one cycle: ascending, back to back.
        do_clear();
        bus.valid = (NP'(1) << 0) | (NP'(1) << 3) | (NP'(1) << 41);
        cycle();
        bus.valid = '0;
        cycle();
        check("batch_ev0", bus.ev_index, CI + 0);
        check("batch_v0", bus.ev_valid, 1);
        cycle();
        check("batch_ev1", bus.ev_index, CI + 3);
        check("batch_v1", bus.ev_valid, 1);
        cycle();
        check("batch_ev2", bus.ev_index, CI + 41);
        check("batch_v2", bus.ev_valid, 1);
        check("batch_hit_count", bus.hit_count, 3);
        cycle();
        check("batch_done", bus.ev_valid, 0);

        // Backpressure with every point hit at once.
        do_clear();
        bus.ev_ready = 1'b0;
        bus.valid    = '1;
        cycle();
        bus.valid = '0;
        repeat (8) cycle();
        check("bp_ev_valid", bus.ev_valid, 1);
        check("bp_ev_index", bus.ev_index, CI);
        check("bp_hit_count", bus.hit_count, NP);
        check("bp_all_covered", bus.all_covered, 1);
        pop_log.delete();
        drain("bp_drained");
        check("bp_event_count", pop_log.size(), NP);
        for (int i = 0; i < NP && i < pop_log.size(); i++) begin
            check("bp_order", pop_log[i], CI + i);
        end

        // Repeated strobe on one point yields one event.
        do_clear();
        pop_log.delete();
        bus.valid = NP'(1) << 7;
        repeat (10) cycle();
        bus.valid = '0;
        repeat (5) cycle();
        check("repeat_count", pop_log.size(), 1);
        if (pop_log.size() > 0) check("repeat_index", pop_log[0], CI + 7);

        // Clear wins over a simultaneous strobe.
        bus.valid = NP'(1) << 9;
        cycle();
        bus.valid = NP'(1) << 2;
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        bus.valid = '0;
        check("clr_hit_map", bus.hit_map, 0);
        check("clr_hit_count", bus.hit_count, 0);
        check("clr_ev_valid", bus.ev_valid, 0);
        repeat (3) cycle();
        check("clr_no_event", bus.ev_valid, 0);
        bus.valid = NP'(1) << 2;
        cycle();
        bus.valid = '0;
        cycle();
        check("clr_rehit_valid", bus.ev_valid, 1);
        check("clr_rehit_index", bus.ev_index, CI + 2);
        cycle();

        // Reset during a backpressured drain.
        do_clear();
        bus.ev_ready = 1'b0;
        bus.valid    = '1;
        repeat (5) cycle();
        reset = 1'b0;
        cycle();
        check("rstmid_ev_valid", bus.ev_valid, 0);
        check("rstmid_hit_map", bus.hit_map, 0);
        check("rstmid_hit_count", bus.hit_count, 0);
        check("rstmid_all_covered", bus.all_covered, 0);
        reset        = 1'b1;
        bus.valid    = '0;
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("rstmid_no_stale", bus.ev_valid, 0);
        end

        // Randomized traffic with sporadic clears and resets.
        for (int n = 0; n < 1500; n++) begin
            bus.valid = '0;
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                    bus.valid[$urandom_range(0, NP - 1)] = 1'b1;
                end
            end
            if ($urandom_range(0, 99) == 0) bus.valid = '1;
            bus.ev_ready = ($urandom_range(0, 3) != 0);
            bus.clear    = ($urandom_range(0, 59) == 0);
            reset        = ($urandom_range(0, 199) != 0);
            cycle();
        end
        bus.clear = 1'b0;
        reset     = 1'b1;
        drain("rand_drained");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/toggle_cover_collector.md
TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 SHALL have parameter N_POINTS, default 42, number of toggle cover points on the valid bus.
REQ-002 SHALL have parameter COVER_INDEX, default 0, global index of valid[0].
REQ-003 SHALL have parameter IDX_WIDTH, default 32, width of reported global index.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries, power of two, >=2.
REQ-005 SHALL have port gbl_clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port valid  input  N_POINTS  per-point hit strobes, sampled every cycle.
REQ-008 SHALL have port clear  input  1  synchronous coverage clear request.
REQ-009 SHALL have port ev_valid  output  1  event available.
REQ-010 SHALL have port ev_ready  input  1  event consumer ready.
REQ-011 SHALL have port ev_index  output  IDX_WIDTH  global index (COVER_INDEX+i) of a first-hit point.
REQ-012 SHALL have port hit_map  output  N_POINTS  sticky per-point covered bitmap.
REQ-013 SHALL have port hit_count  output  $clog2(N_POINTS+1)  number of set bits in hit_map.
REQ-014 SHALL have port all_covered  output  1  high when hit_count == N_POINTS.

Function
REQ-015 SHALL compute new = valid & ~hit_map each cycle; only new bits generate events.
REQ-016 SHALL set hit_map[i] and pending[i] at edge t+1 when new[i] is high in cycle t.
REQ-017 SHALL increment hit_count at the same edge by popcount(new), never exceeding N_POINTS.
REQ-018 SHALL generate at most one event per point between clears; repeated valid[i] after first hit ignored.
REQ-019 SHALL use a two-state FSM: IDLE (pending == 0) and DRAIN (pending != 0); IDLE->DRAIN when pending becomes nonzero, DRAIN->IDLE when last pending bit is pushed and no new bits arrive.
REQ-020 SHALL in DRAIN push one entry per cycle: lowest-index set bit of pending, value COVER_INDEX+i truncated to IDX_WIDTH, clearing that pending bit.
REQ-021 SHALL stall the push (pending unchanged) while FIFO is full; no event is ever dropped.
REQ-022 SHALL permit push and pop in the same cycle when full if ev_ready && ev_valid.
REQ-023 SHALL drive ev_valid = FIFO not empty; ev_index = FIFO head; transfer on ev_valid && ev_ready.
REQ-024 SHALL hold ev_index stable while ev_valid && !ev_ready.
REQ-025 SHALL deliver events in ascending index order within a simultaneous batch; batches in arrival order per pending scan.
REQ-026 SHALL give minimum latency valid[i] at cycle t -> ev_valid with ev_index at cycle t+2.
REQ-027 SHALL on clear high at cycle t zero hit_map, pending, hit_count and FIFO at edge t+1, FSM to IDLE; valid in cycle t ignored (clear wins).
REQ-028 SHALL treat new bits arriving while DRAIN is active by ORing them into pending, same edge as the pending bit being pushed is cleared.
REQ-029 SHALL compute all_covered combinationally from hit_count.

Reset
REQ-030 SHALL on reset low at a rising edge set hit_map=0, pending=0, hit_count=0, FIFO empty, ev_valid=0, all_covered=0, FSM=IDLE, regardless of valid/clear.
REQ-031 SHALL abort any drain in progress when reset asserts; no event emitted in the cycle after reset.
REQ-032 SHALL ignore valid while reset is low.

Verification
REQ-033 SHALL test single hit: N_POINTS=42, COVER_INDEX=100, valid[5] pulse at t, ev_ready=1 -> ev_valid at t+2 with ev_index=105, hit_count=1.
REQ-034 SHALL test batch: valid=bits{0,3,41} one cycle, ev_ready=1 -> events 100,103,141 on consecutive cycles, hit_count=3.
REQ-035 SHALL test backpressure: ev_ready=0, valid=all ones -> FIFO fills to FIFO_DEPTH, ev_index=100 held, hit_count=42, all_covered=1; release ev_ready -> 42 events 100..141 in order, none lost or duplicated.
REQ-036 SHALL test repeat: valid[7] held high 10 cycles -> exactly one event 107.
REQ-037 SHALL test clear with simultaneous valid[2] -> hit_map=0, hit_count=0, ev_valid=0 next cycle; later valid[2] -> event 102.
REQ-038 SHALL test reset mid-drain: reset low during backpressured drain -> all outputs zero next cycle, no stale event after reset release.
